// File: rtl/spi_xfer_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter_if
//   Connects the transfer arbiter to the SPI_Master controller inputs and to
//   its completion outputs.
//
//   Parameters: reg_wid (transfer word width), num (size field is num+1 bits)
//   Signals:
//     m_start    arbiter -> master   one-cycle transfer start
//     m_data_in  arbiter -> master   TX word
//     m_size     arbiter -> master   number of bits to shift
//     m_slave    arbiter -> master   slave address
//     m_cphase   arbiter -> master   clock phase
//     m_data_out master  -> arbiter  RX word
//     m_done     master  -> arbiter  one-cycle completion pulse
//   Modports: master (arbiter side), slave (SPI_Master side)
// ---------------------------------------------------------------------------
interface spi_xfer_arbiter_if #(
    parameter int reg_wid = 8,
    parameter int num     = $clog2(reg_wid)
);
    logic               m_start;
    logic [reg_wid-1:0] m_data_in;
    logic [num:0]       m_size;
    logic [1:0]         m_slave;
    logic               m_cphase;
    logic [reg_wid-1:0] m_data_out;
    logic               m_done;

    modport master (
        output m_start, m_data_in, m_size, m_slave, m_cphase,
        input  m_data_out, m_done
    );

    modport slave (
        input  m_start, m_data_in, m_size, m_slave, m_cphase,
        output m_data_out, m_done
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
//   Shares one SPI_Master datapath among NREQ requesters. A round-robin
//   winner is picked in IDLE, its configuration is latched onto the master
//   inputs in ARB, a one-cycle start is issued in START, the arbiter then
//   waits for the master's completion in WAIT and reports done (and err) in
//   DONE. Transfers with size 0 or size > reg_wid are rejected without
//   starting the master.
//
//   Optional feature macro: SPI_ARB_TIMEOUT_EN
//     Defined   : WAIT aborts with err after TIMEOUT cycles without m_done.
//     Undefined : WAIT holds until m_done or reset; no timer exists.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     req        in   per-requester request level, held until own done
//     req_data   in   per-requester TX word   [i*reg_wid +: reg_wid]
//     req_size   in   per-requester bit count [i*(num+1) +: num+1]
//     req_slave  in   per-requester slave     [i*2 +: 2]
//     req_cphase in   per-requester clock phase
//     gnt        out  one-hot grant, held from ARB through DONE
//     done       out  one-cycle completion pulse to the granted requester
//     err        out  one-cycle pulse with done on reject/timeout
//     rdata      out  RX word of the last successful transfer
//     busy       out  high in every state except IDLE
//     m_bus      master modport towards SPI_Master
// ---------------------------------------------------------------------------
module spi_xfer_arbiter #(
    parameter int reg_wid = 8,
    parameter int num     = $clog2(reg_wid),
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*reg_wid-1:0]   req_data,
    input  logic [NREQ*(num+1)-1:0]   req_size,
    input  logic [NREQ*2-1:0]         req_slave,
    input  logic [NREQ-1:0]           req_cphase,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [reg_wid-1:0]        rdata,
    output logic                      busy,
    spi_xfer_arbiter_if.master        m_bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = num + 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_params
        $error("spi_xfer_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    typedef enum logic [2:0] {IDLE, ARB, START, WAIT, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    pick;
    logic [SW-1:0]    win_size;
    logic [NREQ-1:0]  win_onehot;
    logic             size_bad;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    logic [TW-1:0]    timer;
`endif

    // Round-robin search: walk offsets from the highest down so the lowest
    // offset from rr_ptr (the first set bit going upward with wrap) wins.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it holding its old value and infer a latch.
    always_comb begin
        pick = rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NREQ]) begin
                pick = PW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign win_size   = req_size[int'(winner)*SW +: SW];
    assign win_onehot = NREQ'(1) << winner;
    assign size_bad   = (win_size == '0) || (win_size > SW'(reg_wid));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            winner           <= '0;
            gnt              <= '0;
            done             <= '0;
            err              <= 1'b0;
            rdata            <= '0;
            busy             <= 1'b0;
            m_bus.m_start    <= 1'b0;
            m_bus.m_data_in  <= '0;
            m_bus.m_size     <= '0;
            m_bus.m_slave    <= '0;
            m_bus.m_cphase   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            timer            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner <= pick;
                        gnt    <= NREQ'(1) << pick;
                        busy   <= 1'b1;
                        state  <= ARB;
                    end
                end

                ARB: begin
                    m_bus.m_data_in <= req_data[int'(winner)*reg_wid +: reg_wid];
                    m_bus.m_size    <= win_size;
                    m_bus.m_slave   <= req_slave[int'(winner)*2 +: 2];
                    m_bus.m_cphase  <= req_cphase[winner];
                    if (size_bad) begin
                        // Rejected: report straight away, the master never starts.
                        done  <= win_onehot;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        m_bus.m_start <= 1'b1;
                        state         <= START;
                    end
                end

                START: begin
                    m_bus.m_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    timer         <= '0;
`endif
                    state         <= WAIT;
                end

                WAIT: begin
                    // m_done has priority over the timeout limit in the same cycle.
                    if (m_bus.m_done) begin
                        rdata <= m_bus.m_data_out;
                        done  <= win_onehot;
                        state <= DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT - 1)) begin
                        done  <= win_onehot;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                DONE: begin
                    done   <= '0;
                    err    <= 1'b0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_arbiter
//   Directed self-checking bench for spi_xfer_arbiter (reg_wid=8, NREQ=4).
//   With SPI_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT=16 and the
//   timeout paths are exercised; otherwise an indefinite WAIT hold is checked.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [15:0] req_size;
    logic [7:0]  req_slave;
    logic [3:0]  req_cphase;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    spi_xfer_arbiter_if #(.reg_wid(8)) m_bus ();

    spi_xfer_arbiter #(.reg_wid(8), .NREQ(4), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_size   (req_size),
        .req_slave  (req_slave),
        .req_cphase (req_cphase),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .m_bus      (m_bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] sz,
                           input logic [1:0] sl, input logic cp);
        req_data[i*8 +: 8]  = d;
        req_size[i*4 +: 4]  = sz;
        req_slave[i*2 +: 2] = sl;
        req_cphase[i]       = cp;
    endtask

    // One complete good transfer starting from IDLE with req already driven.
    task automatic xfer(input string tag, input logic [3:0] exp_gnt,
                        input logic [7:0] exp_tx, input logic [7:0] rx);
        tick;
        check({tag, "_gnt"}, gnt, exp_gnt);
        tick;
        check({tag, "_start"}, m_bus.m_start, 1);
        check({tag, "_tx"}, m_bus.m_data_in, exp_tx);
        tick;
        check({tag, "_start_off"}, m_bus.m_start, 0);
        m_bus.m_data_out = rx;
        m_bus.m_done     = 1'b1;
        tick;
        m_bus.m_done     = 1'b0;
        check({tag, "_done"}, done, exp_gnt);
        check({tag, "_err"}, err, 0);
        check({tag, "_rdata"}, rdata, rx);
        tick;
        check({tag, "_idle_gnt"}, gnt, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        req = '0; req_data = '0; req_size = '0; req_slave = '0; req_cphase = '0;
        m_bus.m_done = 1'b0; m_bus.m_data_out = '0;

        // Reset state
        tick; tick;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_start", m_bus.m_start, 0);
        check("rst_size", m_bus.m_size, 0);
        rst = 1'b1;

        // Single transfer from requester 0
        set_req(0, 8'hAA, 4'd8, 2'd0, 1'b0);
        set_req(1, 8'h11, 4'd8, 2'd1, 1'b0);
        set_req(2, 8'h22, 4'd8, 2'd2, 1'b1);
        set_req(3, 8'h99, 4'd8, 2'd3, 1'b1);
        req = 4'b0001;
        tick;
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_nostart", m_bus.m_start, 0);
        tick;
        check("t1_start", m_bus.m_start, 1);
        check("t1_tx", m_bus.m_data_in, 8'hAA);
        check("t1_size", m_bus.m_size, 4'd8);
        check("t1_slave", m_bus.m_slave, 2'd0);
        tick;
        check("t1_start_one", m_bus.m_start, 0);
        m_bus.m_data_out = 8'h55; m_bus.m_done = 1'b1;
        tick;
        m_bus.m_done = 1'b0;
        check("t1_done", done, 4'b0001);
        check("t1_err", err, 0);
        check("t1_rdata", rdata, 8'h55);
        req = 4'b0000;
        tick;
        check("t1_done_pulse", done, 0);
        check("t1_gnt_off", gnt, 0);
        check("t1_busy_off", busy, 0);

        // Asynchronous reset while in WAIT (rr_ptr is 1 here)
        req = 4'b0010;
        tick;
        check("rw_gnt", gnt, 4'b0010);
        tick; tick;
        check("rw_wait_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rw_gnt0", gnt, 0);
        check("rw_busy0", busy, 0);
        check("rw_tx0", m_bus.m_data_in, 0);
        check("rw_size0", m_bus.m_size, 0);
        check("rw_rdata0", rdata, 0);
        req = 4'b0000;
        tick;
        rst = 1'b1;
        req = 4'b1000;
        xfer("rw_r3", 4'b1000, 8'h99, 8'h3C);

        // Round robin with all requesters held: rr_ptr wrapped to 0
        req = 4'b1111;
        xfer("rr_a0", 4'b0001, 8'hAA, 8'hA1);
        xfer("rr_a1", 4'b0010, 8'h11, 8'hA2);
        xfer("rr_a2", 4'b0100, 8'h22, 8'hA3);
        xfer("rr_a3", 4'b1000, 8'h99, 8'hA4);
        req = 4'b0101;
        xfer("rr_b0", 4'b0001, 8'hAA, 8'hB1);
        xfer("rr_b2", 4'b0100, 8'h22, 8'hB2);
        req = 4'b0000;

        // Size 0 on requester 1 (rr_ptr is 3): rejected, no start
        set_req(1, 8'h11, 4'd0, 2'd1, 1'b0);
        req = 4'b0010;
        tick;
        check("sz0_gnt", gnt, 4'b0010);
        tick;
        check("sz0_nostart", m_bus.m_start, 0);
        check("sz0_done", done, 4'b0010);
        check("sz0_err", err, 1);
        check("sz0_rdata", rdata, 8'hB2);
        tick;
        check("sz0_done_off", done, 0);
        check("sz0_err_off", err, 0);
        check("sz0_gnt_off", gnt, 0);

        // Size 9 (> reg_wid) on requester 1 (rr_ptr is 2): rejected
        set_req(1, 8'h11, 4'd9, 2'd1, 1'b0);
        tick;
        check("sz9_gnt", gnt, 4'b0010);
        tick;
        check("sz9_nostart", m_bus.m_start, 0);
        check("sz9_err", err, 1);
        check("sz9_done", done, 4'b0010);
        req = 4'b0000;
        tick;

        // m_done while IDLE is ignored
        m_bus.m_data_out = 8'hEE; m_bus.m_done = 1'b1;
        tick;
        m_bus.m_done = 1'b0;
        check("idle_mdone_busy", busy, 0);
        check("idle_mdone_done", done, 0);
        check("idle_mdone_rdata", rdata, 8'hB2);

        // Requester 2 drops req during WAIT; m_* stay latched
        set_req(2, 8'h3C, 4'd5, 2'd2, 1'b1);
        req = 4'b0100;
        tick;
        check("drop_gnt", gnt, 4'b0100);
        tick;
        check("drop_start", m_bus.m_start, 1);
        tick;
        req = 4'b0000;
        set_req(2, 8'hFF, 4'd7, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("drop_tx", m_bus.m_data_in, 8'h3C);
            check("drop_size", m_bus.m_size, 4'd5);
            check("drop_slave", m_bus.m_slave, 2'd2);
            check("drop_cphase", m_bus.m_cphase, 1);
            check("drop_gnt_hold", gnt, 4'b0100);
            check("drop_no_done", done, 0);
        end
        m_bus.m_data_out = 8'hC3; m_bus.m_done = 1'b1;
        tick;
        m_bus.m_done = 1'b0;
        check("drop_done", done, 4'b0100);
        check("drop_err", err, 0);
        check("drop_rdata", rdata, 8'hC3);
        tick;
        check("drop_idle", busy, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Timeout with TIMEOUT=16 (rr_ptr is 3)
        req = 4'b1000;
        tick; tick; tick;
        for (int i = 1; i <= 15; i++) begin
            tick;
            check("to_no_done", done, 0);
        end
        tick;
        check("to_done", done, 4'b1000);
        check("to_err", err, 1);
        check("to_rdata", rdata, 8'hC3);
        req = 4'b0000;
        tick;
        // m_done on the limit cycle wins (rr_ptr is 0)
        req = 4'b0001;
        tick; tick; tick;
        repeat (15) tick;
        check("tl_still_wait", done, 0);
        m_bus.m_data_out = 8'h5A; m_bus.m_done = 1'b1;
        tick;
        m_bus.m_done = 1'b0;
        check("tl_done", done, 4'b0001);
        check("tl_err", err, 0);
        check("tl_rdata", rdata, 8'h5A);
        req = 4'b0000;
        tick;
`else
        // Without the timeout WAIT holds well past the default limit
        req = 4'b1000;
        tick; tick; tick;
        repeat (70) tick;
        check("hold_no_done", done, 0);
        check("hold_busy", busy, 1);
        check("hold_gnt", gnt, 4'b1000);
        m_bus.m_data_out = 8'h5A; m_bus.m_done = 1'b1;
        tick;
        m_bus.m_done = 1'b0;
        check("hold_done", done, 4'b1000);
        check("hold_err", err, 0);
        check("hold_rdata", rdata, 8'h5A);
        req = 4'b0000;
        tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one SPI_Master datapath among NREQ requesters, each with its own slave address, size, phase and TX byte.
- Round-robin grant; latches the winner's config onto the master controller inputs and issues a one-cycle start.
- Waits for the master's completion pulse, returns the received word and a per-requester done pulse.
- Sits between client logic and SPI_Master; sole driver of master start/data_in/size/slave/cphase.

Parameters:
- reg_wid, 8, transfer word width (matches master).
- num, $clog2(reg_wid), size field is num+1 bits.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, WAIT-state cycle limit (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  request per requester; level, held until own done.
- req_data  in  NREQ*reg_wid  TX word; requester i at bits [i*reg_wid +: reg_wid].
- req_size  in  NREQ*(num+1)  bits to shift, per requester.
- req_slave  in  NREQ*2  slave address, per requester.
- req_cphase  in  NREQ  clock phase, per requester.
- gnt  out  NREQ  one-hot grant, held ARB..DONE.
- done  out  NREQ  one-cycle completion pulse to granted requester.
- err  out  1  one-cycle pulse with done on rejected or timed-out transfer.
- rdata  out  reg_wid  received word from the last successful transfer.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  start to master.
- m_data_in  out  reg_wid  TX word to master.
- m_size  out  num+1  size to master.
- m_slave  out  2  slave address to master.
- m_cphase  out  1  phase to master.
- m_data_out  in  reg_wid  master RX word.
- m_done  in  1  one-cycle pulse from master datapath on entering unload.

Behaviour:
- Reset values (async, rst=0): all outputs 0; state IDLE; rr_ptr 0; timer 0.
- States: IDLE, ARB, START, WAIT, DONE.
- IDLE: if |req, register winner = first set bit searching from rr_ptr upward with wrap; then go to ARB. Latency is 1 cycle from req to gnt.
- ARB: gnt[winner]=1. Latch the winner's data/size/slave/cphase into m_* registers.
  - If size==0 or size>reg_wid: go to DONE with err set; no m_start issued.
  - Otherwise go to START.
- START: m_start=1 for exactly one cycle; go to WAIT.
- WAIT: m_* held stable.
  - On m_done: rdata<=m_data_out, then go to DONE.
  - m_done seen in any other state is ignored.
- DONE: done[winner]=1 and err as set for 1 cycle. Then gnt<=0, rr_ptr<=(winner+1) mod NREQ, and return to IDLE.
  - At least one IDLE cycle always separates transfers.
- req deasserted while granted: ignored; the transfer completes and done still pulses.
- New req arriving during busy: waits; it is never lost, because req is a level.
- rr_ptr advances only in DONE, including after an err completion.
- rdata is unchanged on err.
- Reset mid-transfer: immediate return to reset values; m_start is deasserted even in START.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined: an 8-bit-minimum timer clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with no m_done, go to DONE with err=1; rdata is unchanged.
  - m_done in the same cycle as the limit wins, with no err.
- Undefined: WAIT holds indefinitely until m_done or reset; err is driven only by the size check; no timer logic is synthesised.

Test Plan:
- Single req[0], data 8'hAA, size 8, slave 0: gnt=0001 one cycle after req, then one m_start cycle; m_done with m_data_out=8'h55 -> rdata=8'h55, done=0001 for one cycle, err=0.
- req=1111 held for 4 transfers: grant order 0,1,2,3; then with req=0101 the order is 0,2; each gnt is one-hot and separated by an IDLE cycle.
- req[1] with size 0 -> gnt=0010, no m_start, done[1] and err pulse together, rdata unchanged.
- Reset (rst=0) during WAIT: all outputs 0 asynchronously; after release with req[3] set, grant goes to 3 with rr_ptr restarting at 0.
- SPI_ARB_TIMEOUT_EN, TIMEOUT=16, m_done never asserted -> done and err pulse 16 cycles after WAIT entry; a second run with m_done on cycle 15 gives no err.
- req[2] dropped during WAIT -> transfer still completes, done[2] pulses, m_* stable throughout WAIT.
